// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential sign-magnitude fixed-point divider (restoring, one
// quotient bit per clock). Inverse of qmult; saturates on overflow or /0.
module qdiv_seq #(
  parameter int Q = 23,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic         ovf,
  output logic         dz
);

  localparam int ITER = N - 1 + Q;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, nstate;
  logic [ITER-1:0] dvd, quo, quo_nx;
  logic [N-1:0]    rem, rem_sh, rem_nx;
  logic [N-2:0]    bmag, mag_nx;
  logic [CW-1:0]   cnt;
  logic            sign, ge, ovf_nx, done_d, bzero;

  assign busy  = (state != IDLE);
  assign bzero = (b[N-2:0] == '0);

  // One restoring step: shift in next dividend bit, trial-subtract |b|.
  // A set carry bit means the shifted remainder is certainly >= |b|.
  always_comb begin
    rem_sh = {rem[N-2:0], dvd[ITER-1]};
    ge     = rem[N-1] | (rem_sh >= {1'b0, bmag});
    rem_nx = ge ? (rem_sh - {1'b0, bmag}) : rem_sh;
    quo_nx = {quo[ITER-2:0], ge};
    ovf_nx = |quo_nx[ITER-1:N-1];
    mag_nx = ovf_nx ? '1 : quo_nx[N-2:0];
  end

  // Next-state and done pulse; DONE spends one quiet cycle then one done cycle.
  always_comb begin
    nstate = state;
    done_d = 1'b0;
    case (state)
      IDLE: if (start) nstate = bzero ? DONE : RUN;
      RUN:  if (cnt == '0) nstate = DONE;
      DONE: begin
        done_d = ~done;
        if (done) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      done  <= done_d;
    end
  end

  // Datapath: operand latch on accept, iteration in RUN, result on last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd      <= '0;
      quo      <= '0;
      rem      <= '0;
      bmag     <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      quotient <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd  <= {a[N-2:0], {Q{1'b0}}};
          bmag <= b[N-2:0];
          sign <= a[N-1] ^ b[N-1];
          rem  <= '0;
          quo  <= '0;
          cnt  <= CW'(ITER - 1);
          ovf  <= 1'b0;
          dz   <= bzero;
          // Saturated magnitude is never zero, so the sign is kept.
          if (bzero) quotient <= {a[N-1] ^ b[N-1], {(N-1){1'b1}}};
        end
        RUN: begin
          dvd <= {dvd[ITER-2:0], 1'b0};
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient <= {sign & (|mag_nx), mag_nx};
            ovf      <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed bench for qdiv_seq at default Q=23, N=32 (ITER=54).
module tb_qdiv_seq;
  localparam int N = 32;
  localparam int ITER = 54;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         busy, done, ovf, dz;
  logic [N-1:0] quotient;
  int checks = 0, errors = 0;

  qdiv_seq #(.Q(23), .N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation; optionally hammer start with other operands mid-run.
  task automatic run_op(input string tag, input logic [N-1:0] aa, input logic [N-1:0] bb,
                        input int exp_lat, input logic [N-1:0] exp_q,
                        input logic exp_ovf, input logic exp_dz, input bit disturb);
    int lat;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, N'(busy), N'(1));
    chk({tag, "_flagclr"}, N'({ovf, dz}), N'(exp_lat == 2 ? 2'b01 : 2'b00));
    while (!done && lat < 200) begin
      if (disturb && lat == 5) begin
        a = 32'h7F800000; b = 32'h00400000; start = 1'b1;
      end
      if (disturb && lat == 8) begin
        start = 1'b0; a = '0; b = '0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, N'(lat), N'(exp_lat));
    chk({tag, "_q"}, quotient, exp_q);
    chk({tag, "_flags"}, N'({ovf, dz}), N'({exp_ovf, exp_dz}));
    @(negedge clk);
    chk({tag, "_idle"}, N'({busy, done}), N'(2'b00));
    chk({tag, "_hold"}, quotient, exp_q);
  endtask

  initial begin
    bit seen;
    #12;
    chk("rst_out", N'({busy, done, ovf, dz}), N'(0));
    chk("rst_q", quotient, '0);
    @(negedge clk);
    rst = 1'b0;

    run_op("neg7p5_div_2p5", 32'h83C00000, 32'h01400000, ITER + 2, 32'h81800000, 0, 0, 0);
    run_op("one_third",      32'h00800000, 32'h01800000, ITER + 2, 32'h002AAAAA, 0, 0, 0);
    run_op("ovf_pos",        32'h7F800000, 32'h00400000, ITER + 2, 32'h7FFFFFFF, 1, 0, 0);
    run_op("ovf_neg",        32'hFF800000, 32'h00400000, ITER + 2, 32'hFFFFFFFF, 1, 0, 0);
    run_op("dz_negzero",     32'h80800000, 32'h80000000, 2,        32'h7FFFFFFF, 0, 1, 0);
    run_op("dz_poszero",     32'h00800000, 32'h00000000, 2,        32'h7FFFFFFF, 0, 1, 0);
    run_op("zero_div_neg",   32'h00000000, 32'h81000000, ITER + 2, 32'h00000000, 0, 0, 0);
    run_op("neg_small",      32'h80800000, 32'h01800000, ITER + 2, 32'h802AAAAA, 0, 0, 0);
    run_op("ignored_start",  32'h00800000, 32'h01800000, ITER + 2, 32'h002AAAAA, 0, 0, 1);

    // Reset mid-operation aborts at once and no done follows.
    @(negedge clk);
    a = 32'h00800000; b = 32'h01800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", N'(busy), N'(1));
    rst = 1'b1;
    #1;
    chk("abort_out", N'({busy, done}), N'(0));
    chk("abort_q", quotient, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (ITER + 10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", N'(seen), N'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
